ysyx_040750_csr_bypass_tracker: RTL
===================================

# ysyx_040750_csr_bypass_tracker

Parametrised CSR hazard tracker and forwarding unit for the ysyx_040750 pipeline. It keeps its own shift register of in-flight CSR writes from EX to WB instead of taking per-stage address/enable/data buses. It answers ID-stage CSR reads with the youngest matching in-flight value, or raises a hazard when that value is not yet computed. It also drives the CSR-file write port from its oldest entry. It sits between ID decode, the EX CSR ALU and the CSR register file.

## Interface
- XLEN, 64, CSR data width
- ADDR_W, 12, CSR address width
- STAGES, 3, in-flight entries tracked (entry 0 = EX, entry STAGES-1 = WB); legal range 2..6
- I_sys_clk  in  1  clock; all state updates on its rising edge
- I_rst_n  in  1  reset, asynchronous assert, active-low; clears all state
- I_stall  in  1  global pipeline hold; entries do not move
- I_flush  in  1  trap/mret/redirect; kills every in-flight entry
- I_issue  in  1  instruction leaves ID this cycle (ignored while I_stall)
- I_csr_wen_ID  in  1  issuing instruction writes a CSR
- I_csr_ren_ID  in  1  ID instruction reads a CSR
- I_csr_addr_ID  in  ADDR_W  CSR address in ID
- I_csr_rdata_ID  in  XLEN  CSR-file read data for I_csr_addr_ID
- I_csr_wdata_EX  in  XLEN  new CSR value computed in EX
- I_csr_wdata_vld_EX  in  1  I_csr_wdata_EX is final this cycle
- O_csr_fwd_data  out  XLEN  value ID uses for the CSR read
- O_csr_hazard  out  1  ID must stall: youngest match has no data yet
- O_csr_wb_en  out  1  CSR-file write enable
- O_csr_wb_addr  out  ADDR_W  CSR-file write address
- O_csr_wb_data  out  XLEN  CSR-file write data

## Operation
- Entry fields: vld, addr, data, dok (data ok).
- Advance when !I_stall:
  - entry 0 <= {I_issue & I_csr_wen_ID, I_csr_addr_ID, 0, 0};
  - entry k <= entry k-1 for k ≥ 1;
  - when entry 0 moves to entry 1, its data/dok are replaced by I_csr_wdata_EX / I_csr_wdata_vld_EX.
- While I_stall, entries hold, except entry 0: if vld and I_csr_wdata_vld_EX, it captures data and sets dok.
- I_flush (priority over stall and issue): all vld bits cleared next cycle. The entry in WB at the flush cycle still retires if it is valid (it is older than the trap).
- Lookup (combinational, youngest first, entry 0 → STAGES-1): first valid entry with addr == I_csr_addr_ID wins.
  - Entry 0 hit: data = I_csr_wdata_EX when I_csr_wdata_vld_EX; otherwise hazard.
  - Entry k ≥ 1 hit: data = entry.data when dok; otherwise hazard.
  - No hit: O_csr_fwd_data = I_csr_rdata_ID.
- O_csr_hazard = I_csr_ren_ID & winning hit not ready. Forwarding is gated by I_csr_ren_ID only for the hazard output; data still muxes.
- Retire: O_csr_wb_en = entry[STAGES-1].vld & entry[STAGES-1].dok & !I_stall. A WB entry with vld & !dok is a protocol error and is not written.

## Timing
- Lookup and hazard: zero latency (combinational from entries and ID/EX inputs).
- A write issued at cycle t:
  - is visible for forwarding from t+1;
  - retires on the CSR port at cycle t+STAGES (no stalls);
  - is visible in I_csr_rdata_ID from t+STAGES+1.
- Back-to-back writes to the same address: the younger one always wins.
- Reset: all vld/dok = 0; data = 0; O_csr_wb_en = 0; O_csr_hazard = 0. O_csr_fwd_data equals I_csr_rdata_ID.
- Reset mid-operation discards all in-flight entries with no writeback.

## Configuration
- YSYX_040750_CSR_HAZARD_CNT_EN defined:
  - adds output O_hazard_cnt [31:0], counting cycles with O_csr_hazard = 1;
  - saturates at 0xFFFFFFFF and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package ysyx_040750_pkg: XLEN/ADDR_W defaults and a csr_entry_t struct {vld, addr, data, dok}.
- One sub-module, ysyx_040750_csr_prio_match: parametrised youngest-first match/select over STAGES entries.
- The top level holds the shift register, retire logic and optional counter.

## Test plan
- Issue a write to 0x300 with wdata 0x8 valid in EX, then read 0x300 in the next cycle → fwd_data 0x8, hazard 0; WB write 0x300/0x8 at t+3.
- Issue a write to 0x341 with wdata_vld 0, then read 0x341 → hazard 1. Raise wdata_vld with 0x1234 → hazard 0, fwd 0x1234.
- Writes to 0x305 with 0xA then 0xB in consecutive cycles, then read 0x305 → 0xB. One cycle after 0xA retires → still 0xB.
- Writes in EX and MEM, then assert I_flush → only the WB entry retires. Next cycle a read of 0x300 returns I_csr_rdata_ID.
- Hold I_stall 4 cycles with a pending entry → no retire and entries frozen. Release → retire on the third cycle after release.
- With YSYX_040750_CSR_HAZARD_CNT_EN defined, 5 hazard cycles → O_hazard_cnt = 5. Assert reset mid-sequence → 0 and no writeback.

Source files
------------

// File: rtl/ysyx_040750_pkg.sv
// Shared CSR tracker types: default widths and the in-flight CSR write entry.
package ysyx_040750_pkg;

  localparam int unsigned CSR_XLEN_DEFAULT   = 64;
  localparam int unsigned CSR_ADDR_W_DEFAULT = 12;

  typedef struct packed {
    logic                          vld;
    logic [CSR_ADDR_W_DEFAULT-1:0] addr;
    logic [CSR_XLEN_DEFAULT-1:0]   data;
    logic                          dok;
  } csr_entry_t;

endpackage

// File: rtl/ysyx_040750_csr_prio_match.sv
// Youngest-first address match over STAGES in-flight CSR entries (index 0 is youngest).
module ysyx_040750_csr_prio_match
  import ysyx_040750_pkg::*;
#(
  parameter int unsigned XLEN   = CSR_XLEN_DEFAULT,
  parameter int unsigned ADDR_W = CSR_ADDR_W_DEFAULT,
  parameter int unsigned STAGES = 3
) (
  input  logic [STAGES-1:0]             vld,
  input  logic [STAGES-1:0]             rdy,
  input  logic [STAGES-1:0][ADDR_W-1:0] addr,
  input  logic [STAGES-1:0][XLEN-1:0]   data,
  input  logic [ADDR_W-1:0]             key,
  output logic                          hit,
  output logic                          hit_rdy,
  output logic [XLEN-1:0]               hit_data
);

  // Scan oldest to youngest so the youngest matching entry overwrites any older one.
  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (vld[i] && (addr[i] == key)) begin
        hit      = 1'b1;
        hit_rdy  = rdy[i];
        hit_data = data[i];
      end
    end
  end

endmodule

// File: rtl/ysyx_040750_csr_bypass_tracker.sv
// CSR write tracker from EX to WB with ID-stage forwarding, hazard detect and CSR-file retire.
// Optional hazard-cycle counter enabled by defining YSYX_040750_CSR_HAZARD_CNT_EN.
module ysyx_040750_csr_bypass_tracker
  import ysyx_040750_pkg::*;
#(
  parameter int unsigned XLEN   = CSR_XLEN_DEFAULT,
  parameter int unsigned ADDR_W = CSR_ADDR_W_DEFAULT,
  parameter int unsigned STAGES = 3
) (
  input  logic              I_sys_clk,
  input  logic              I_rst_n,
  input  logic              I_stall,
  input  logic              I_flush,
  input  logic              I_issue,
  input  logic              I_csr_wen_ID,
  input  logic              I_csr_ren_ID,
  input  logic [ADDR_W-1:0] I_csr_addr_ID,
  input  logic [XLEN-1:0]   I_csr_rdata_ID,
  input  logic [XLEN-1:0]   I_csr_wdata_EX,
  input  logic              I_csr_wdata_vld_EX,
  output logic [XLEN-1:0]   O_csr_fwd_data,
  output logic              O_csr_hazard,
  output logic              O_csr_wb_en,
  output logic [ADDR_W-1:0] O_csr_wb_addr,
`ifdef YSYX_040750_CSR_HAZARD_CNT_EN
  output logic [31:0]       O_hazard_cnt,
`endif
  output logic [XLEN-1:0]   O_csr_wb_data
);

  csr_entry_t [STAGES-1:0] ent_q, ent_d;

  always_comb begin
    ent_d = ent_q;
    if (I_flush) begin
      ent_d = '0;
    end else if (I_stall) begin
      // EX may finish its result while the pipe is held.
      if (ent_q[0].vld && I_csr_wdata_vld_EX) begin
        ent_d[0].data = I_csr_wdata_EX;
        ent_d[0].dok  = 1'b1;
      end
    end else begin
      for (int k = 2; k < int'(STAGES); k++) begin
        ent_d[k] = ent_q[k-1];
      end
      ent_d[1].vld  = ent_q[0].vld;
      ent_d[1].addr = ent_q[0].addr;
      ent_d[1].data = I_csr_wdata_vld_EX ? I_csr_wdata_EX : ent_q[0].data;
      ent_d[1].dok  = ent_q[0].dok | I_csr_wdata_vld_EX;
      ent_d[0].vld  = I_issue & I_csr_wen_ID;
      ent_d[0].addr = I_csr_addr_ID;
      ent_d[0].data = '0;
      ent_d[0].dok  = 1'b0;
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  // Entry 0 sits in EX, so its value comes straight from the EX result bus.
  logic [STAGES-1:0]             m_vld, m_rdy;
  logic [STAGES-1:0][ADDR_W-1:0] m_addr;
  logic [STAGES-1:0][XLEN-1:0]   m_data;

  always_comb begin
    m_vld  = '0;
    m_rdy  = '0;
    m_addr = '0;
    m_data = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      m_vld[i]  = ent_q[i].vld;
      m_addr[i] = ent_q[i].addr;
      m_rdy[i]  = (i == 0) ? I_csr_wdata_vld_EX : ent_q[i].dok;
      m_data[i] = (i == 0) ? I_csr_wdata_EX : ent_q[i].data;
    end
  end

  logic            hit, hit_rdy;
  logic [XLEN-1:0] hit_data;

  ysyx_040750_csr_prio_match #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W),
    .STAGES (STAGES)
  ) u_prio_match (
    .vld      (m_vld),
    .rdy      (m_rdy),
    .addr     (m_addr),
    .data     (m_data),
    .key      (I_csr_addr_ID),
    .hit      (hit),
    .hit_rdy  (hit_rdy),
    .hit_data (hit_data)
  );

  assign O_csr_fwd_data = hit ? hit_data : I_csr_rdata_ID;
  assign O_csr_hazard   = I_csr_ren_ID & hit & ~hit_rdy;

  // A WB entry without data is a protocol error and is dropped rather than written.
  assign O_csr_wb_en   = ent_q[STAGES-1].vld & ent_q[STAGES-1].dok & ~I_stall;
  assign O_csr_wb_addr = ent_q[STAGES-1].addr;
  assign O_csr_wb_data = ent_q[STAGES-1].data;

`ifdef YSYX_040750_CSR_HAZARD_CNT_EN
  logic [31:0] hazard_cnt_q;

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      hazard_cnt_q <= '0;
    end else if (O_csr_hazard && (hazard_cnt_q != 32'hFFFF_FFFF)) begin
      hazard_cnt_q <= hazard_cnt_q + 32'd1;
    end
  end

  assign O_hazard_cnt = hazard_cnt_q;
`endif

endmodule
